alu_mc: RTL and testbench

- Parametrised multi-cycle ALU for the datapath's execute stage.
- Extends the single-cycle ALU with:
  - configurable WIDTH
  - XOR/NOR/unsigned-compare/shift ops
  - signed overflow flag
  - iterative unsigned multiply and divide
- All results are registered behind a start/busy/done handshake, so the controller stalls until done is asserted.

---
 rtl/alu_mc.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_mc.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc
// Multi-cycle ALU for the execute stage. Single-cycle logic, arithmetic,
// compare and shift ops finish one clock after they are accepted. Unsigned
// multiply (low/high half) and unsigned divide/remainder run iteratively,
// one bit per clock, and finish WIDTH+2 clocks after they are accepted.
// Every result is registered and announced with a one-cycle done pulse.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  accept an operation (only honoured while idle)
//   ctrl   operation select, sampled with start
//   a, b   operands, sampled with start (shift amount is b[SHW-1:0])
//   y      registered result
//   zero   registered, set when y is zero
//   ovf    registered signed overflow for ADD/SUB, otherwise 0
//   busy   high while an iterative operation is in flight
//   done   one-cycle pulse when y/zero/ovf are updated
// ---------------------------------------------------------------------------
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIN  = 2'd2
   } AluState;

   AluState state;
   AluState stateNext;

   logic             isIterOp;
   logic             acceptSingle;
   logic             acceptIter;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] aluRes;
   logic             aluOvf;

   logic [SHW-1:0]     cnt;
   logic [1:0]         iterOp;
   logic [WIDTH-1:0]   opA;
   logic [WIDTH-1:0]   opB;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;

   logic [WIDTH-1:0]   mulAddend;
   logic [WIDTH:0]     mulSum;
   logic [2*WIDTH-1:0] prodNext;
   logic [WIDTH:0]     remShift;
   logic [WIDTH:0]     remSub;
   logic               remFits;
   logic [WIDTH-1:0]   remNext;
   logic [WIDTH-1:0]   quoNext;
   logic [WIDTH-1:0]   iterRes;

   // The two top ctrl bits set mark the iterative group; everything else
   // completes in a single clock and never leaves IDLE.
   assign isIterOp     = (ctrl[3:2] == 2'b11);
   assign acceptSingle = (state == IDLE) && start && !isIterOp;
   assign acceptIter   = (state == IDLE) && start && isIterOp;
   assign shamt        = b[SHW-1:0];
   assign sum          = a + b;
   assign diff         = a - b;

   // Single-cycle result and overflow. Overflow only has meaning for ADD
   // and SUB; every other op reports 0. Reserved codes yield 0.
   always_comb begin
      aluRes = '0;
      aluOvf = 1'b0;
      case (ctrl)
         4'b0000: aluRes = a & b;
         4'b0001: aluRes = a | b;
         4'b0010: begin
            aluRes = sum;
            aluOvf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0110: begin
            aluRes = diff;
            aluOvf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0011: aluRes = a ^ b;
         4'b0100: aluRes = ~(a | b);
         4'b0111: aluRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         4'b0101: aluRes = {{(WIDTH-1){1'b0}}, (a < b)};
         4'b1000: aluRes = a << shamt;
         4'b1001: aluRes = a >> shamt;
         4'b1010: aluRes = $unsigned($signed(a) >>> shamt);
         default: aluRes = '0;
      endcase
   end

   // Shift-add multiply step: the multiplier sits in the low half of the
   // product register and is consumed one bit per clock from the LSB while
   // the partial sum (with its carry) shifts down from the top.
   assign mulAddend = prod[0] ? opA : '0;
   assign mulSum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mulAddend};
   assign prodNext  = {mulSum, prod[WIDTH-1:1]};

   // Restoring divide step: bring down the next dividend bit, subtract the
   // divisor when it fits and record a quotient bit. A zero divisor always
   // "fits", which naturally produces an all-ones quotient and leaves the
   // dividend in the remainder without any special-case logic.
   assign remShift = {rem, quo[WIDTH-1]};
   assign remFits  = (remShift >= {1'b0, opB});
   assign remSub   = remShift - {1'b0, opB};
   assign remNext  = remFits ? remSub[WIDTH-1:0] : remShift[WIDTH-1:0];
   assign quoNext  = {quo[WIDTH-2:0], remFits};

   // Pick which half / which divider output is the final iterative result.
   always_comb begin
      iterRes = '0;
      case (iterOp)
         2'b00: iterRes = prod[WIDTH-1:0];
         2'b01: iterRes = prod[2*WIDTH-1:WIDTH];
         2'b10: iterRes = quo;
         2'b11: iterRes = rem;
         default: iterRes = '0;
      endcase
   end

   // State register. Reset drops any in-flight operation immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic. ITER always runs exactly WIDTH clocks (no early exit
   // for small operands or zero divisors) so latency is fixed.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (acceptIter) stateNext = ITER;
         ITER: if (cnt == SHW'(WIDTH-1)) stateNext = FIN;
         FIN:  stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Iteration datapath: operands are captured at accept, then only the
   // unit selected by the op advances each ITER clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         iterOp <= '0;
         opA    <= '0;
         opB    <= '0;
         prod   <= '0;
         rem    <= '0;
         quo    <= '0;
      end else if (acceptIter) begin
         cnt    <= '0;
         iterOp <= ctrl[1:0];
         opA    <= a;
         opB    <= b;
         prod   <= {{WIDTH{1'b0}}, b};
         rem    <= '0;
         quo    <= a;
      end else if (state == ITER) begin
         cnt <= cnt + 1'b1;
         if (iterOp[1]) begin
            rem <= remNext;
            quo <= quoNext;
         end else begin
            prod <= prodNext;
         end
      end
   end

   // Result/flag registers and handshake. Outputs only change together with
   // a done pulse; otherwise they hold. busy rises on an iterative accept and
   // falls in the same clock the iterative result is written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y    <= '0;
         zero <= 1'b1;
         ovf  <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (acceptSingle) begin
            y    <= aluRes;
            zero <= (aluRes == '0);
            ovf  <= aluOvf;
            done <= 1'b1;
         end else if (acceptIter) begin
            busy <= 1'b1;
         end else if (state == FIN) begin
            y    <= iterRes;
            zero <= (iterRes == '0);
            ovf  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc
// Directed testbench for alu_mc (WIDTH=32). Each vector carries a
// hand-computed expected result; latency and busy duration are counted
// against the fixed single-cycle and WIDTH+2 iterative timing.
// ---------------------------------------------------------------------------
module tb_alu_mc;

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  ctrl;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] y;
   logic        zero;
   logic        ovf;
   logic        busy;
   logic        done;

   int checks;
   int failures;
   int lat;
   int busyCnt;
   int doneCount;
   int doneLat;
   logic [31:0] doneY;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_NOR   = 4'b0100;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_SLTU  = 4'b0101;
   localparam logic [3:0] OP_SLL   = 4'b1000;
   localparam logic [3:0] OP_SRL   = 4'b1001;
   localparam logic [3:0] OP_SRA   = 4'b1010;
   localparam logic [3:0] OP_RSV   = 4'b1011;
   localparam logic [3:0] OP_MUL   = 4'b1100;
   localparam logic [3:0] OP_MULHU = 4'b1101;
   localparam logic [3:0] OP_DIVU  = 4'b1110;
   localparam logic [3:0] OP_REMU  = 4'b1111;

   alu_mc #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .ctrl  (ctrl),
      .a     (a),
      .b     (b),
      .y     (y),
      .zero  (zero),
      .ovf   (ovf),
      .busy  (busy),
      .done  (done)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Present one op for a single clock (driven on a falling edge), then wait
   // falling edge by falling edge until done, counting latency in clocks and
   // how many of those clocks showed busy. Bounded so a dead DUT still ends.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] opa,
                                input logic [31:0] opb, output int latOut,
                                output int busyOut);
      @(negedge clk);
      start = 1'b1;
      ctrl  = op;
      a     = opa;
      b     = opb;
      latOut  = 0;
      busyOut = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         latOut++;
         if (busy) busyOut++;
      end while (!done && latOut < 200);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst   = 1'b1;
      start = 1'b0;
      ctrl  = 4'b0000;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);

      // Reset values
      checkOutput("rst_y", y, 32'h0);
      checkOutput("rst_zero", {31'b0, zero}, 32'h1);
      checkOutput("rst_ovf", {31'b0, ovf}, 32'h0);
      checkOutput("rst_busy", {31'b0, busy}, 32'h0);
      checkOutput("rst_done", {31'b0, done}, 32'h0);
      rst = 1'b0;

      // Reset in the middle of a multiply
      applyStimulus(OP_ADD, 32'h10, 32'h20, lat, busyCnt);
      checkOutput("pre_add_y", y, 32'h30);
      @(negedge clk);
      start = 1'b1; ctrl = OP_MUL; a = 32'h5; b = 32'h6;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("mid_mul_busy", {31'b0, busy}, 32'h1);
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_busy", {31'b0, busy}, 32'h0);
      checkOutput("midrst_done", {31'b0, done}, 32'h0);
      checkOutput("midrst_y", y, 32'h0);
      checkOutput("midrst_zero", {31'b0, zero}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
      doneCount = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("midrst_no_done", doneCount, 0);
      applyStimulus(OP_ADD, 32'd3, 32'd4, lat, busyCnt);
      checkOutput("add34_lat", lat, 1);
      checkOutput("add34_y", y, 32'd7);

      // Signed / unsigned compare
      applyStimulus(OP_SLT, 32'hFFFF_FFFF, 32'h1, lat, busyCnt);
      checkOutput("slt_neg_y", y, 32'h1);
      applyStimulus(OP_SLTU, 32'hFFFF_FFFF, 32'h1, lat, busyCnt);
      checkOutput("sltu_y", y, 32'h0);
      checkOutput("sltu_zero", {31'b0, zero}, 32'h1);
      applyStimulus(OP_SLT, 32'd5, 32'd5, lat, busyCnt);
      checkOutput("slt_eq_y", y, 32'h0);
      checkOutput("slt_eq_zero", {31'b0, zero}, 32'h1);

      // Overflow and shifts
      applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'h1, lat, busyCnt);
      checkOutput("add_ovf_y", y, 32'h8000_0000);
      checkOutput("add_ovf", {31'b0, ovf}, 32'h1);
      checkOutput("add_ovf_zero", {31'b0, zero}, 32'h0);
      applyStimulus(OP_SUB, 32'h8000_0000, 32'h1, lat, busyCnt);
      checkOutput("sub_ovf_y", y, 32'h7FFF_FFFF);
      checkOutput("sub_ovf", {31'b0, ovf}, 32'h1);
      applyStimulus(OP_SUB, 32'd5, 32'd3, lat, busyCnt);
      checkOutput("sub_y", y, 32'd2);
      checkOutput("sub_noovf", {31'b0, ovf}, 32'h0);
      applyStimulus(OP_SRA, 32'h8000_0000, 32'h24, lat, busyCnt);
      checkOutput("sra_y", y, 32'hF800_0000);
      checkOutput("sra_ovf", {31'b0, ovf}, 32'h0);
      applyStimulus(OP_SRL, 32'h8000_0000, 32'h4, lat, busyCnt);
      checkOutput("srl_y", y, 32'h0800_0000);
      applyStimulus(OP_SLL, 32'h1, 32'h1F, lat, busyCnt);
      checkOutput("sll_y", y, 32'h8000_0000);

      // Logic ops and reserved code
      applyStimulus(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, lat, busyCnt);
      checkOutput("and_y", y, 32'h00F0_1234);
      applyStimulus(OP_OR, 32'hF000_0000, 32'h0000_000F, lat, busyCnt);
      checkOutput("or_y", y, 32'hF000_000F);
      applyStimulus(OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, lat, busyCnt);
      checkOutput("xor_y", y, 32'hF0F0_0F0F);
      applyStimulus(OP_NOR, 32'h0, 32'h0, lat, busyCnt);
      checkOutput("nor_y", y, 32'hFFFF_FFFF);
      applyStimulus(OP_RSV, 32'd5, 32'd3, lat, busyCnt);
      checkOutput("rsv_y", y, 32'h0);
      checkOutput("rsv_zero", {31'b0, zero}, 32'h1);

      // Multiply
      applyStimulus(OP_MUL, 32'h0001_0000, 32'h0001_0000, lat, busyCnt);
      checkOutput("mul_lat", lat, 34);
      checkOutput("mul_busy_cycles", busyCnt, 33);
      checkOutput("mul_busy_at_done", {31'b0, busy}, 32'h0);
      checkOutput("mul_y", y, 32'h0);
      checkOutput("mul_zero", {31'b0, zero}, 32'h1);
      applyStimulus(OP_MULHU, 32'h0001_0000, 32'h0001_0000, lat, busyCnt);
      checkOutput("mulhu_y", y, 32'h1);
      checkOutput("mulhu_zero", {31'b0, zero}, 32'h0);
      applyStimulus(OP_MUL, 32'd7, 32'd6, lat, busyCnt);
      checkOutput("mul76_y", y, 32'd42);
      applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busyCnt);
      checkOutput("mulhu_max_y", y, 32'hFFFF_FFFE);
      applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busyCnt);
      checkOutput("mul_max_y", y, 32'h1);
      checkOutput("mul_ovf", {31'b0, ovf}, 32'h0);

      // Divide
      applyStimulus(OP_DIVU, 32'd100, 32'd7, lat, busyCnt);
      checkOutput("divu_lat", lat, 34);
      checkOutput("divu_y", y, 32'd14);
      applyStimulus(OP_REMU, 32'd100, 32'd7, lat, busyCnt);
      checkOutput("remu_y", y, 32'd2);
      applyStimulus(OP_DIVU, 32'd9, 32'd0, lat, busyCnt);
      checkOutput("divu0_lat", lat, 34);
      checkOutput("divu0_y", y, 32'hFFFF_FFFF);
      applyStimulus(OP_REMU, 32'd9, 32'd0, lat, busyCnt);
      checkOutput("remu0_y", y, 32'd9);
      applyStimulus(OP_DIVU, 32'hFFFF_FFFF, 32'h10, lat, busyCnt);
      checkOutput("divu_big_y", y, 32'h0FFF_FFFF);

      // Handshake: an ADD offered during a divide must be dropped
      @(negedge clk);
      start = 1'b1; ctrl = OP_DIVU; a = 32'd100; b = 32'd7;
      doneCount = 0;
      doneLat   = 0;
      doneY     = '0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (i == 5) begin
            start = 1'b1; ctrl = OP_ADD; a = 32'd1; b = 32'd1;
         end
         if (done) begin
            doneCount++;
            doneLat = i;
            doneY   = y;
         end
      end
      start = 1'b0;
      checkOutput("hs_done_count", doneCount, 1);
      checkOutput("hs_done_lat", doneLat, 34);
      checkOutput("hs_div_y", doneY, 32'd14);

      // Back-to-back single-cycle ops give consecutive done pulses
      start = 1'b1; ctrl = OP_ADD; a = 32'd1; b = 32'd2;
      @(negedge clk);
      checkOutput("b2b_done1", {31'b0, done}, 32'h1);
      checkOutput("b2b_y1", y, 32'd3);
      a = 32'd5; b = 32'd6;
      @(negedge clk);
      start = 1'b0;
      checkOutput("b2b_done2", {31'b0, done}, 32'h1);
      checkOutput("b2b_y2", y, 32'd11);
      @(negedge clk);
      checkOutput("b2b_done_low", {31'b0, done}, 32'h0);
      checkOutput("b2b_y_hold", y, 32'd11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
